data_posit_decoder: RTL

Pipelined posit<16,1> decoder. It splits a posit word into the sign, scale-factor and fraction fields that `data_posit_encoder` consumes, plus zero/NaR flags. It sits at the operand-input side of the posit adder and multiplier datapaths. With `i_guard=0` and `i_sticky=0`, the encoder returns the original word bit-exactly for every one of the 2^16 inputs. It accepts one word per cycle through a valid/ready handshake.

---
 rtl/posit_pkg.sv | 18 +
 rtl/posit_lzoc.sv | 32 +++
 rtl/data_posit_decoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// Shared constants for the posit<16,1> datapath.
//
// Holds the word width, exponent size, encoder field widths and the two
// special encodings. Both the decoder and its run-length counter import it.
package posit_pkg;

    localparam int POSIT_N  = 16;
    localparam int POSIT_ES = 1;

    // Field widths shared with data_posit_encoder.
    localparam int SF_W   = POSIT_N - 9;
    localparam int MANT_W = POSIT_N - 4;
    localparam int RUN_W  = $clog2(POSIT_N);

    localparam logic [POSIT_N-1:0] POSIT_ZERO = 16'h0000;
    localparam logic [POSIT_N-1:0] POSIT_NAR  = 16'h8000;

endpackage

// File: rtl/posit_lzoc.sv
// Leading zero/one counter for the posit regime.
//
// Counts how many bits, starting at body[N-2], are equal to body[N-2].
// The result is always in 1..N-1 because the first bit always matches itself.
//
// Ports:
//   body  in  N-1    posit word without its sign bit
//   m     out RUN_W  regime run length
module posit_lzoc
    import posit_pkg::*;
#(
    parameter int N = POSIT_N
) (
    input  logic [N-2:0]     body,
    output logic [RUN_W-1:0] m
);

    logic running;

    always_comb begin
        m       = '0;
        running = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (running && (body[i] == body[N-2])) begin
                m = m + RUN_W'(1);
            end else begin
                running = 1'b0;
            end
        end
    end

endmodule

// File: rtl/data_posit_decoder.sv
// Two-stage pipelined posit<16,1> decoder.
//
// Splits a posit word into the sign / scale-factor / fraction fields that
// data_posit_encoder consumes, plus zero and NaR flags. Negative words are
// not negated; the regime and exponent are emitted in the sign-XOR form the
// encoder expects, so encoder(decoder(w)) == w with guard = sticky = 0.
//
// Ports:
//   i_clk    in   1     clock, rising edge
//   i_rst    in   1     synchronous active-high reset
//   i_valid  in   1     input word present
//   o_ready  out  1     decoder can take i_posit this cycle
//   i_posit  in   N     posit word
//   o_valid  out  1     output fields valid
//   i_ready  in   1     downstream takes the outputs
//   o_s      out  1     sign
//   o_sf     out  N-9   {rc, k field (5b), exponent field (1b)}
//   o_mant   out  N-4   raw fraction, left-aligned, zero-padded
//   o_nzn    out  1     word is neither zero nor NaR
//   o_nar    out  1     word is NaR
//
// Handshake: a word moves across an interface on a rising edge where that
// interface's valid and ready are both high. The producer holds valid and
// data steady until that edge; ready may depend combinationally on the
// consumer's ready (o_ready follows i_ready, there is no skid buffer).
module data_posit_decoder
    import posit_pkg::*;
#(
    parameter int N = POSIT_N
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [N-1:0]  i_posit,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_s,
    output logic [N-10:0] o_sf,
    output logic [N-5:0]  o_mant,
    output logic          o_nzn,
    output logic          o_nar
);

    localparam int K_W = SF_W - 1 - POSIT_ES;

    // ---------------- stage 1: word capture and run length ----------------
    logic                s1_valid;
    logic                s1_s;
    logic                s1_r0;
    logic [N-4:0]        s1_tail;   // bits below the first regime bit pair
    logic                s1_zero;
    logic                s1_nar;
    logic [RUN_W-1:0]    s1_m;

    logic [RUN_W-1:0]    in_m;
    logic                s1_load;
    logic                s2_adv;

    posit_lzoc #(.N(N)) u_lzoc (
        .body (i_posit[N-2:0]),
        .m    (in_m)
    );

    // S2 takes new contents when it is empty or its word leaves this edge.
    assign s2_adv  = ~o_valid | i_ready;
    assign o_ready = ~s1_valid | s2_adv;
    assign s1_load = i_valid & o_ready;

    // ---------------- stage 2 field extraction ----------------
    // body[N-3] is either the second run bit or the terminator, so only the
    // bits below it can hold exponent/fraction. Shifting them left by m-1
    // puts the exponent bit at the top and the fraction directly below it;
    // for m >= N-2 everything shifts out, giving e = 0 and an empty fraction.
    logic [MANT_W:0]     shifted;
    logic                rc;
    logic [K_W-1:0]      k_field;
    logic                e_field;
    logic                special;
    logic [SF_W-1:0]     sf_next;
    logic [MANT_W-1:0]   mant_next;

    always_comb begin
        shifted   = s1_tail << (s1_m - RUN_W'(1));
        rc        = ~s1_r0 ^ s1_s;
        k_field   = K_W'(s1_m - RUN_W'(1)) ^ {K_W{rc}};
        e_field   = shifted[MANT_W] ^ s1_s;
        special   = s1_zero | s1_nar;
        sf_next   = special ? '0 : {rc, k_field, e_field};
        mant_next = special ? '0 : shifted[MANT_W-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_s     <= 1'b0;
            s1_r0    <= 1'b0;
            s1_tail  <= '0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_m     <= '0;
            o_valid  <= 1'b0;
            o_s      <= 1'b0;
            o_sf     <= '0;
            o_mant   <= '0;
            o_nzn    <= 1'b0;
            o_nar    <= 1'b0;
        end else begin
            if (o_ready) begin
                s1_valid <= i_valid;
            end
            if (s1_load) begin
                s1_s    <= i_posit[N-1];
                s1_r0   <= i_posit[N-2];
                s1_tail <= i_posit[N-4:0];
                s1_zero <= (i_posit == POSIT_ZERO);
                s1_nar  <= (i_posit == POSIT_NAR);
                s1_m    <= in_m;
            end
            if (s2_adv) begin
                o_valid <= s1_valid;
                if (s1_valid) begin
                    o_s    <= s1_s;
                    o_sf   <= sf_next;
                    o_mant <= mant_next;
                    o_nzn  <= ~special;
                    o_nar  <= s1_nar;
                end
            end
        end
    end

endmodule
